// File: rtl/writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// pa_core_pkg
// Shared widths and the write-back entry type for the PA_core writeback stage.
//   REG_ADDR_W : register-file address width
//   DATA_W     : register-file data width
//   wb_entry_t : one pending register write {dst, data}
// ---------------------------------------------------------------------------
package pa_core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage : pa_core_pkg

// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Groups the ALU result handshake, the memory result handshake and the
// register-file write port of the writeback stage.
//   alu_valid/alu_dst/alu_data -> ALU result offer,  alu_ready <- FIFO space
//   mem_valid/mem_dst/mem_data -> load result offer, mem_ready <- enable
//   WB/WB_add/datain           <- registered write to Decode
// Modports: master (producer side / bench), slave (writeback_unit).
// ---------------------------------------------------------------------------
interface writeback_unit_if;
    import pa_core_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0]     alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_ready;

    logic                  WB;
    logic [REG_ADDR_W-1:0] WB_add;
    logic [DATA_W-1:0]     datain;

    modport master (
        output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
        input  alu_ready, mem_ready, WB, WB_add, datain
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
        output alu_ready, mem_ready, WB, WB_add, datain
    );

endinterface : writeback_unit_if

// File: rtl/writeback_unit_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry synchronous FIFO of wb_entry_t holding queued ALU results.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_entry at the tail (caller guarantees not full)
//   i_entry      : entry to write
//   i_pop        : drop the head entry (caller guarantees not empty)
//   o_head       : current head entry
//   o_count      : occupancy, 0..DEPTH
//   o_valid_mask : one bit per storage slot, set when that slot is occupied
//   o_dst_all    : destination field of every storage slot
// DEPTH must be a power of 2 so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module wb_fifo
    import pa_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_push,
    input  wb_entry_t                             i_entry,
    input  logic                                  i_pop,
    output wb_entry_t                             o_head,
    output logic [$clog2(DEPTH+1)-1:0]            o_count,
    output logic [DEPTH-1:0]                      o_valid_mask,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      o_dst_all
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Storage, pointers and occupancy; reset drops every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        o_valid_mask = {DEPTH{1'b0}};
        o_dst_all    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid_mask[i] = (CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count);
            o_dst_all[i]    = r_mem[i].dst;
        end
    end

endmodule : wb_fifo

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Final PA_core stage: merges ALU results (queued in wb_fifo) and load
// results (priority, never queued) onto the Decode register-file write port.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : pipeline enable; one write issues per enabled edge
//   bus (slave)        : ALU/mem handshakes and the registered WB port
//   count, stall       : FIFO occupancy and full flag
//   src1_reg, src2_reg : Decode source registers for the hazard compare
//   hazard             : a source matches a pending write
// Build option: define WB_HAZARD_EN to enable the hazard compare; otherwise
// hazard is tied low and the source ports are unused.
// ---------------------------------------------------------------------------
module writeback_unit
    import pa_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    writeback_unit_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        stall,
    input  logic [REG_ADDR_W-1:0]       src1_reg,
    input  logic [REG_ADDR_W-1:0]       src2_reg,
    output logic                        hazard
);

    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t                         w_head;
    wb_entry_t                         w_alu_entry;
    logic [CNT_W-1:0]                  w_count;
    logic [DEPTH-1:0]                  w_valid_mask;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  w_dst_all;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_alu_ready;

    logic                              r_wb;
    logic [REG_ADDR_W-1:0]             r_wb_add;
    logic [DATA_W-1:0]                 r_datain;

    // Full FIFO refuses pushes even on a popping edge: no pass-through path.
    assign w_alu_ready = (w_count != CNT_W'(DEPTH));
    assign w_push      = bus.alu_valid & w_alu_ready;
    // Memory results own the port, so the FIFO only drains on mem-free edges.
    assign w_pop       = enable & ~bus.mem_valid & (w_count != CNT_W'(0));
    assign w_alu_entry = '{dst: bus.alu_dst, data: bus.alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_entry      (w_alu_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_valid_mask (w_valid_mask),
        .o_dst_all    (w_dst_all)
    );

    // Issue arbitration: mem first, then FIFO head; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb     <= 1'b0;
            r_wb_add <= {REG_ADDR_W{1'b0}};
            r_datain <= {DATA_W{1'b0}};
        end else if (enable) begin
            if (bus.mem_valid) begin
                r_wb     <= 1'b1;
                r_wb_add <= bus.mem_dst;
                r_datain <= bus.mem_data;
            end else if (w_count != CNT_W'(0)) begin
                r_wb     <= 1'b1;
                r_wb_add <= w_head.dst;
                r_datain <= w_head.data;
            end else begin
                r_wb     <= 1'b0;
            end
        end else begin
            r_wb <= 1'b0;
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.mem_ready = enable;
    assign bus.WB        = r_wb;
    assign bus.WB_add    = r_wb_add;
    assign bus.datain    = r_datain;
    assign count         = w_count;
    assign stall         = (w_count == CNT_W'(DEPTH));

`ifdef WB_HAZARD_EN
    logic w_hazard;

    // Any queued, in-flight load or currently driven write targeting a source.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hazard = w_hazard | (w_valid_mask[i] &
                       ((w_dst_all[i] == src1_reg) | (w_dst_all[i] == src2_reg)));
        end
        w_hazard = w_hazard | (bus.mem_valid &
                   ((bus.mem_dst == src1_reg) | (bus.mem_dst == src2_reg)));
        w_hazard = w_hazard | (r_wb &
                   ((r_wb_add == src1_reg) | (r_wb_add == src2_reg)));
    end

    assign hazard = w_hazard;
`else
    logic w_unused_hazard;
    assign w_unused_hazard = ^{w_valid_mask, w_dst_all, src1_reg, src2_reg};
    assign hazard          = 1'b0;
`endif

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import pa_core_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] count;
    logic       stall;
    logic [4:0] src1_reg;
    logic [4:0] src2_reg;
    logic       hazard;

    int n_checks;
    int n_fail;

    writeback_unit_if u_bus ();

    writeback_unit #(.DEPTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (u_bus),
        .count    (count),
        .stall    (stall),
        .src1_reg (src1_reg),
        .src2_reg (src2_reg),
        .hazard   (hazard)
    );

`ifdef WB_HAZARD_EN
    localparam logic HZ_ON = 1'b1;
`else
    localparam logic HZ_ON = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [4:0] dst, input logic [31:0] data);
        u_bus.alu_valid = 1'b1;
        u_bus.alu_dst   = dst;
        u_bus.alu_data  = data;
        tick();
        u_bus.alu_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        src1_reg = 5'd0;
        src2_reg = 5'd0;
        u_bus.alu_valid = 1'b0;
        u_bus.alu_dst   = 5'd0;
        u_bus.alu_data  = 32'd0;
        u_bus.mem_valid = 1'b0;
        u_bus.mem_dst   = 5'd0;
        u_bus.mem_data  = 32'd0;

        // Reset state
        #2;
        check("rst_wb", {31'd0, u_bus.WB}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_ready", {31'd0, u_bus.alu_ready}, 32'd1);
        check("rst_add", {27'd0, u_bus.WB_add}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single ALU push then issue
        enable = 1'b1;
        check("mem_ready_en", {31'd0, u_bus.mem_ready}, 32'd1);
        push_idle(5'd5, 32'h1234);
        check("t2_cnt1", {29'd0, count}, 32'd1);
        check("t2_wb_early", {31'd0, u_bus.WB}, 32'd0);
        tick();
        check("t2_wb", {31'd0, u_bus.WB}, 32'd1);
        check("t2_add", {27'd0, u_bus.WB_add}, 32'd5);
        check("t2_data", u_bus.datain, 32'h1234);
        check("t2_cnt0", {29'd0, count}, 32'd0);
        tick();
        check("t2_wb_drop", {31'd0, u_bus.WB}, 32'd0);
        check("t2_add_hold", {27'd0, u_bus.WB_add}, 32'd5);

        // Fill while disabled, then drain in order
        enable = 1'b0;
        check("mem_ready_dis", {31'd0, u_bus.mem_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) push_idle(5'(i), 32'(i) * 32'h11);
        check("t3_cnt", {29'd0, count}, 32'd4);
        check("t3_stall", {31'd0, stall}, 32'd1);
        check("t3_ready", {31'd0, u_bus.alu_ready}, 32'd0);
        check("t3_wb_dis", {31'd0, u_bus.WB}, 32'd0);
        push_idle(5'd31, 32'hDEAD);
        check("t3_cnt_held", {29'd0, count}, 32'd4);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t3_wb", {31'd0, u_bus.WB}, 32'd1);
            check("t3_add", {27'd0, u_bus.WB_add}, 32'(i));
            check("t3_data", u_bus.datain, 32'(i) * 32'h11);
            check("t3_cnt_dn", {29'd0, count}, 32'(4 - i));
        end
        tick();
        check("t3_idle", {31'd0, u_bus.WB}, 32'd0);

        // Asynchronous reset mid-stream with 3 entries queued
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_idle(5'(20 + i), 32'h100 + 32'(i));
        enable = 1'b1;
        tick();
        check("t1_pre_wb", {31'd0, u_bus.WB}, 32'd1);
        check("t1_pre_cnt", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_wb", {31'd0, u_bus.WB}, 32'd0);
        check("t1_count", {29'd0, count}, 32'd0);
        check("t1_ready", {31'd0, u_bus.alu_ready}, 32'd1);
        check("t1_add", {27'd0, u_bus.WB_add}, 32'd0);
        check("t1_data", u_bus.datain, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t1_post_wb", {31'd0, u_bus.WB}, 32'd0);
        check("t1_post_cnt", {29'd0, count}, 32'd0);

        // Memory result overtakes a queued ALU result
        enable = 1'b0;
        push_idle(5'd3, 32'h33);
        enable = 1'b1;
        u_bus.mem_valid = 1'b1;
        u_bus.mem_dst   = 5'd7;
        u_bus.mem_data  = 32'hAA;
        tick();
        u_bus.mem_valid = 1'b0;
        check("t4_add_mem", {27'd0, u_bus.WB_add}, 32'd7);
        check("t4_data_mem", u_bus.datain, 32'hAA);
        check("t4_cnt_kept", {29'd0, count}, 32'd1);
        tick();
        check("t4_add_alu", {27'd0, u_bus.WB_add}, 32'd3);
        check("t4_data_alu", u_bus.datain, 32'h33);
        check("t4_cnt0", {29'd0, count}, 32'd0);
        tick();

        // Full: pop accepted, push refused; partial: push+pop keeps count
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_idle(5'(10 + i), 32'h200 + 32'(i));
        enable = 1'b1;
        u_bus.alu_valid = 1'b1;
        u_bus.alu_dst   = 5'd14;
        u_bus.alu_data  = 32'h204;
        tick();
        check("t5_full_add", {27'd0, u_bus.WB_add}, 32'd10);
        check("t5_full_cnt", {29'd0, count}, 32'd3);
        tick();
        u_bus.alu_valid = 1'b0;
        check("t5_part_add", {27'd0, u_bus.WB_add}, 32'd11);
        check("t5_part_cnt", {29'd0, count}, 32'd3);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t5_drain_add", {27'd0, u_bus.WB_add}, 32'(10 + i));
            check("t5_drain_data", u_bus.datain, 32'h200 + 32'(i));
        end
        tick();
        check("t5_empty", {29'd0, count}, 32'd0);

        // Hazard compare
        enable   = 1'b0;
        src1_reg = 5'd9;
        src2_reg = 5'd30;
        check("t6_none", {31'd0, hazard}, 32'd0);
        push_idle(5'd9, 32'h99);
        check("t6_queued", {31'd0, hazard}, {31'd0, HZ_ON});
        enable = 1'b1;
        tick();
        check("t6_wb_add9", {27'd0, u_bus.WB_add}, 32'd9);
        check("t6_wb_live", {31'd0, hazard}, {31'd0, HZ_ON});
        tick();
        check("t6_cleared", {31'd0, hazard}, 32'd0);
        enable = 1'b0;
        u_bus.mem_valid = 1'b1;
        u_bus.mem_dst   = 5'd30;
        #1;
        check("t6_mem_src2", {31'd0, hazard}, {31'd0, HZ_ON});
        u_bus.mem_valid = 1'b0;
        #1;
        check("t6_mem_gone", {31'd0, hazard}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_writeback_unit
